grid_display_tx: RTL and testbench

//  Consumer/transmitter end of the tetris_grid readout: periodically snapshots grid_state[199:0],
//  row_cleared and game_over, then streams them to the external display controller over a

---
 rtl/grid_display_tx.sv | 97 +++++++++
 tb/tb_grid_display_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/grid_display_tx.sv
// grid_display_tx: periodic snapshot of the tetris grid streamed to the display board over write-only SPI mode 0
module grid_display_tx #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_CYCLES = 833_333
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [199:0] grid_state,
  input  logic         row_cleared,
  input  logic         game_over,
  output logic         spi_sclk,
  output logic         spi_mosi,
  output logic         spi_cs_n,
  output logic         busy,
  output logic         frame_done
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_END = TW'(FRAME_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   div_q, div_d;
  logic [8:0]      bit_q, bit_d;
  logic [335:0]    sr_q, sr_d, frame;
  logic            pend_q, pend_d, sticky_q, sticky_d, phase_q, phase_d;
  logic            req, div_end;
  assign req     = tmr_q == TMR_END;
  assign div_end = div_q == DIV_END;
  always_comb begin
    frame = '0;
    frame[335:320] = {8'hA5, 6'b0, game_over, sticky_q | row_cleared};
    for (int k = 0; k < 20; k++) frame[319-16*k -: 16] = {1'b0, 5'(k), grid_state[k*10 +: 10]};
  end
  always_comb begin
    state_d  = state_q;
    tmr_d    = req ? '0 : tmr_q + 1'b1;
    pend_d   = (state_q == IDLE) ? 1'b0 : pend_q | req;
    sticky_d = (state_q == LOAD) ? 1'b0 : sticky_q | row_cleared;
    div_d    = div_end ? '0 : div_q + 1'b1;
    phase_d  = phase_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    case (state_q)
      IDLE:  if (req || pend_q) state_d = LOAD;
      LOAD: begin
        sr_d    = frame;
        div_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (div_end) begin
        state_d = SHIFT;
        phase_d = 1'b0;
        bit_d   = 9'd335;
      end
      // data advances only when a high phase ends, i.e. as sclk falls
      SHIFT: if (div_end) begin
        phase_d = !phase_q;
        if (phase_q && bit_q == 9'd0) state_d = HOLD;
        else if (phase_q) begin
          bit_d = bit_q - 1'b1;
          sr_d  = {sr_q[334:0], 1'b0};
        end
      end
      HOLD:  if (div_end) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      pend_q   <= 1'b0;
      sticky_q <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      pend_q   <= pend_d;
      sticky_q <= sticky_d;
      phase_q  <= phase_d;
    end
  end
  assign spi_sclk   = state_q == SHIFT && phase_q;
  assign spi_mosi   = (state_q == SETUP || state_q == SHIFT) && sr_q[335];
  assign spi_cs_n   = !(state_q inside {SETUP, SHIFT, HOLD});
  assign busy       = state_q inside {LOAD, SETUP, SHIFT, HOLD};
  assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_grid_display_tx.sv
// tb_grid_display_tx: decodes the SPI stream and compares frames and timing against a behavioural model
module tb_grid_display_tx;
  localparam int CD = 4, FC = 4000, FC2 = 1000, W = 8000;
  localparam int L = 2 + 2*CD + 336*2*CD;
  logic clk = 0, reset_n = 0, row_cleared = 0, game_over = 0;
  logic [199:0] grid_state = '0;
  logic sclk, mosi, cs_n, busy, fdone, sclk2, mosi2, cs2, busy2, fdone2;
  int ncmp = 0, nerr = 0, cyc = 0;
  logic [335:0] rx = '0, last = '0;
  int nb = 0, last_nb = 0, frames = 0, starts = 0, dones = 0, fall_t = -1, done_t = -1;
  int dones2 = 0, falls2 = 0, fall2_a = -1, fall2_b = -1;
  logic p_cs = 1, p_sclk = 0, p_cs2 = 1;

  always #5 clk = ~clk;

  grid_display_tx #(.CLK_DIV(CD), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n), .grid_state(grid_state), .row_cleared(row_cleared),
    .game_over(game_over), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n),
    .busy(busy), .frame_done(fdone));

  // request period shorter than a frame, to exercise the single pending slot
  grid_display_tx #(.CLK_DIV(CD), .FRAME_CYCLES(FC2)) dut2 (
    .clk(clk), .reset_n(reset_n), .grid_state(grid_state), .row_cleared(row_cleared),
    .game_over(game_over), .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_cs_n(cs2),
    .busy(busy2), .frame_done(fdone2));

  always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      nb = 0; frames = 0; starts = 0; dones = 0; fall_t = -1; done_t = -1;
      dones2 = 0; falls2 = 0; fall2_a = -1; fall2_b = -1;
    end else begin
      if (p_cs && !cs_n) begin nb = 0; fall_t = cyc; starts++; end
      if (!cs_n && sclk && !p_sclk) begin rx = {rx[334:0], mosi}; nb++; end
      if (!p_cs && cs_n) begin last = rx; last_nb = nb; frames++; end
      if (fdone) begin dones++; done_t = cyc; end
      if (fdone2 && cyc < W) dones2++;
      if (p_cs2 && !cs2) begin
        if (falls2 == 0) fall2_a = cyc;
        else if (falls2 == 1) fall2_b = cyc;
        falls2++;
      end
    end
    p_cs = cs_n; p_sclk = sclk; p_cs2 = cs2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [199:0] rand_grid();
    logic [199:0] g = '0;
    for (int i = 0; i < 7; i++) g = {g[167:0], 32'($urandom)};
    return g;
  endfunction

  function automatic logic [15:0] exp_word(int k, logic [199:0] g, logic go, logic clr);
    logic [199:0] t;
    if (k == 0) return {8'hA5, 6'd0, go, clr};
    t = g >> ((k - 1) * 10);
    return {1'b0, 5'(k - 1), t[9:0]};
  endfunction

  // frames start on request edges; a request seen while a frame is in flight queues one restart
  function automatic int model_dones(output int s2);
    int s = FC2, n = 0, r;
    s2 = -1;
    while (s + L - 1 < W) begin
      n++;
      r = (s / FC2 + 1) * FC2;
      s = (r <= s + L) ? s + L + 1 : r;
      if (n == 1) s2 = s;
    end
    return n;
  endfunction

  task automatic wait_frame(input string tag, input int budget);
    int f0 = frames;
    for (int i = 0; i < budget && frames == f0; i++) step();
    chk({tag, "_arrived"}, 64'(frames != f0), 1);
  endtask

  task automatic check_frame(input string tag, input logic [199:0] g, input logic go, input logic clr);
    chk({tag, "_nbits"}, 64'(last_nb), 336);
    for (int k = 0; k < 21; k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(last[335-16*k -: 16]), 64'(exp_word(k, g, go, clr)));
  endtask

  initial begin
    logic [199:0] g;
    int s2, n2, f0, s0;
    reset_n = 0;
    repeat (3) step();
    chk("rst_cs_n", 64'(cs_n), 1);
    chk("rst_sclk", 64'(sclk), 0);
    chk("rst_mosi", 64'(mosi), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(fdone), 0);
    reset_n = 1;

    wait_frame("t1", FC + L + 100);
    check_frame("t1", '0, 0, 0);
    chk("t1_cs_fall_cycle", 64'(fall_t), FC + 1);
    chk("t1_frame_len", 64'(done_t - fall_t), L - 2);
    chk("t1_done_count", 64'(dones), 1);

    g = rand_grid();
    g[9:0] = 10'h200;
    g[199:190] = 10'h3FF;
    grid_state = g;
    wait_frame("t2", FC + 100);
    check_frame("t2", g, 0, 0);
    chk("t2_w1", 64'(last[319:304]), 64'h0200);
    chk("t2_w20", 64'(last[15:0]), 64'h4FFF);

    for (int i = 0; i < 12000 && cyc < W; i++) step();
    n2 = model_dones(s2);
    chk("t5_done_count", 64'(dones2), 64'(n2));
    chk("t5_first_fall", 64'(fall2_a), FC2 + 1);
    chk("t5_pending_fall", 64'(fall2_b), 64'(s2 + 1));

    g = rand_grid();
    grid_state = g;
    game_over = 1;
    row_cleared = 1;
    step();
    row_cleared = 0;
    wait_frame("t3a", FC + 100);
    check_frame("t3a", g, 1, 1);
    g = rand_grid();
    grid_state = g;
    wait_frame("t3b", FC + 100);
    check_frame("t3b", g, 1, 0);

    g = rand_grid();
    grid_state = g;
    game_over = 0;
    s0 = starts;
    for (int i = 0; i < FC + 100 && starts == s0; i++) step();
    chk("t4_started", 64'(starts != s0), 1);
    f0 = frames;
    for (int i = 0; i < L + 100 && frames == f0; i++) begin
      step();
      grid_state = rand_grid();
      game_over = 1'($urandom);
      row_cleared = (i == 50);
    end
    row_cleared = 0;
    chk("t4_arrived", 64'(frames != f0), 1);
    check_frame("t4a", g, 0, 0);
    g = rand_grid();
    grid_state = g;
    game_over = 0;
    wait_frame("t4b", FC + 100);
    check_frame("t4b", g, 0, 1);

    g = rand_grid();
    grid_state = g;
    for (int i = 0; i < FC + L && !(nb == 100 && !cs_n); i++) step();
    chk("t6_reached_bit100", 64'(nb), 100);
    chk("t6_busy_mid", 64'(busy), 1);
    reset_n = 0;
    step();
    chk("t6_cs_n", 64'(cs_n), 1);
    chk("t6_sclk", 64'(sclk), 0);
    chk("t6_mosi", 64'(mosi), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_done", 64'(fdone), 0);
    step();
    reset_n = 1;
    wait_frame("t6", FC + L + 100);
    check_frame("t6", g, 0, 0);
    chk("t6_cs_fall_cycle", 64'(fall_t), FC + 1);
    chk("t6_done_count", 64'(dones), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
